// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared types and defaults for the accumulator CPU sequencer.
// Revision : 1.0 - initial parametrised program sequencer
// ============================================================================
package cpu_pkg;

    localparam int unsigned c_default_addr_width = 5;

    typedef enum logic [1:0] {
        SEQ_RUN   = 2'd0,
        SEQ_HALT  = 2'd1,
        SEQ_FAULT = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/program_sequencer_return_stack.sv
`default_nettype none
// ============================================================================
// Module   : return_stack
// Brief    : LIFO of return addresses; caller never pushes full or pops empty.
// Revision : 1.0 - initial parametrised program sequencer
// ============================================================================
module return_stack #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               push_data,
    output logic [WIDTH-1:0]               top,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned c_lvl_w = $clog2(DEPTH+1);
    localparam int unsigned c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_lvl_w-1:0] c_full_level = c_lvl_w'(DEPTH);
    localparam logic [c_lvl_w-1:0] c_one        = c_lvl_w'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_lvl_w-1:0] r_level;
    logic [c_lvl_w-1:0] w_top_level;

    // Top entry sits one below the level; only meaningful when not empty.
    assign w_top_level = r_level - c_one;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (push) begin
            r_mem[r_level[c_idx_w-1:0]] <= push_data;
            r_level <= r_level + c_one;
        end else if (pop) begin
            r_level <= r_level - c_one;
        end
    end

    assign empty = (r_level == '0);
    assign full  = (r_level == c_full_level);
    assign level = r_level;
    assign top   = empty ? '0 : r_mem[w_top_level[c_idx_w-1:0]];

endmodule
`default_nettype wire

// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : program_sequencer
// Brief    : Instruction address generator with branch, call/return and halt.
// Revision : 1.0 - initial parametrised program sequencer
// ============================================================================
module program_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH  = c_default_addr_width,
    parameter int unsigned            STACK_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0]  RESET_ADDR  = '0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                stall,
    input  logic                                jump,
    input  logic                                branch,
    input  logic                                cond,
    input  logic                                call,
    input  logic                                ret,
    input  logic                                halt,
    input  logic                                resume,
    input  logic [ADDR_WIDTH-1:0]               target,
    output logic [ADDR_WIDTH-1:0]               instruction_address,
    output logic                                halted,
    output logic                                fault,
    output logic                                overflow,
    output logic                                underflow,
    output logic [$clog2(STACK_DEPTH+1)-1:0]    stack_level
);

    localparam logic [ADDR_WIDTH-1:0] c_pc_one = ADDR_WIDTH'(1);

    seq_state_t              r_state;
    seq_state_t              w_next_state;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [ADDR_WIDTH-1:0]   w_next_pc;
    logic [ADDR_WIDTH-1:0]   w_pc_inc;
    logic [ADDR_WIDTH-1:0]   w_top;
    logic                    r_overflow;
    logic                    r_underflow;
    logic                    w_set_overflow;
    logic                    w_set_underflow;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;

    assign w_pc_inc = r_pc + c_pc_one;

    return_stack #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .top       (w_top),
        .level     (stack_level),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= SEQ_RUN;
            r_pc        <= RESET_ADDR;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_pc        <= w_next_pc;
            r_overflow  <= r_overflow  | w_set_overflow;
            r_underflow <= r_underflow | w_set_underflow;
        end
    end

    // Exactly one strobe acts per RUN cycle, chosen by fixed priority.
    always_comb begin
        w_next_state    = r_state;
        w_next_pc       = r_pc;
        w_push          = 1'b0;
        w_pop           = 1'b0;
        w_set_overflow  = 1'b0;
        w_set_underflow = 1'b0;
        case (r_state)
            SEQ_RUN: begin
                if (!stall) begin
                    if (halt) begin
                        w_next_state = SEQ_HALT;
                    end else if (ret) begin
                        if (!w_empty) begin
                            w_next_pc = w_top;
                            w_pop     = 1'b1;
                        end else begin
                            w_set_underflow = 1'b1;
                            w_next_state    = SEQ_FAULT;
                        end
                    end else if (call) begin
                        if (!w_full) begin
                            w_next_pc = target;
                            w_push    = 1'b1;
                        end else begin
                            w_set_overflow = 1'b1;
                            w_next_state   = SEQ_FAULT;
                        end
                    end else if (jump || (branch && cond)) begin
                        w_next_pc = target;
                    end else begin
                        w_next_pc = w_pc_inc;
                    end
                end
            end
            SEQ_HALT: begin
                if (resume) begin
                    w_next_pc    = w_pc_inc;
                    w_next_state = SEQ_RUN;
                end
            end
            default: begin
                w_next_state = SEQ_FAULT;
            end
        endcase
    end

    assign instruction_address = r_pc;
    assign halted              = (r_state == SEQ_HALT);
    assign fault               = (r_state == SEQ_FAULT);
    assign overflow            = r_overflow;
    assign underflow           = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_sequencer
// Brief    : Directed self-checking bench for program_sequencer (5-bit, depth 4).
// Revision : 1.0 - initial parametrised program sequencer
// ============================================================================
module tb_program_sequencer;

    logic       clk;
    logic       rst;
    logic       stall;
    logic       jump;
    logic       branch;
    logic       cond;
    logic       call;
    logic       ret;
    logic       halt;
    logic       resume;
    logic [4:0] target;
    logic [4:0] instruction_address;
    logic       halted;
    logic       fault;
    logic       overflow;
    logic       underflow;
    logic [2:0] stack_level;

    int checks;
    int failures;

    program_sequencer #(
        .ADDR_WIDTH  (5),
        .STACK_DEPTH (4),
        .RESET_ADDR  (5'd0)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall               (stall),
        .jump                (jump),
        .branch              (branch),
        .cond                (cond),
        .call                (call),
        .ret                 (ret),
        .halt                (halt),
        .resume              (resume),
        .target              (target),
        .instruction_address (instruction_address),
        .halted              (halted),
        .fault               (fault),
        .overflow            (overflow),
        .underflow           (underflow),
        .stack_level         (stack_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_strobes();
        stall  = 1'b0;
        jump   = 1'b0;
        branch = 1'b0;
        cond   = 1'b0;
        call   = 1'b0;
        ret    = 1'b0;
        halt   = 1'b0;
        resume = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        #2;
        check("rst_pc", 32'(instruction_address), 32'd0);
        check("rst_level", 32'(stack_level), 32'd0);
        check("rst_flags", {28'd0, halted, fault, overflow, underflow}, 32'd0);
        tick();
        rst = 1'b1;
    endtask

    task automatic check_pc_lvl(input string tag, input int pc, input int lvl);
        check({tag, "_pc"}, 32'(instruction_address), 32'(pc));
        check({tag, "_lvl"}, 32'(stack_level), 32'(lvl));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        target   = 5'd0;
        idle_strobes();
        tick();
        do_reset();

        // Free-running increment with wrap
        for (int i = 1; i <= 33; i++) begin
            tick();
            check("inc_pc", 32'(instruction_address), 32'(i % 32));
        end
        tick(); tick();
        check("pre_jump_pc", 32'(instruction_address), 32'd3);

        jump = 1'b1; target = 5'd20;
        tick();
        check("jump_pc", 32'(instruction_address), 32'd20);
        jump = 1'b0; branch = 1'b1; target = 5'd7; cond = 1'b0;
        tick();
        check("branch_nt_pc", 32'(instruction_address), 32'd21);
        cond = 1'b1;
        tick();
        check("branch_t_pc", 32'(instruction_address), 32'd7);
        idle_strobes();

        // Fill the return stack, then overflow
        do_reset();
        tick();
        check("pre_call_pc", 32'(instruction_address), 32'd1);
        call = 1'b1; target = 5'd10; tick(); check_pc_lvl("call1", 10, 1);
        target = 5'd20; tick(); check_pc_lvl("call2", 20, 2);
        target = 5'd30; tick(); check_pc_lvl("call3", 30, 3);
        target = 5'd5;  tick(); check_pc_lvl("call4", 5, 4);
        check("call4_fault", 32'(fault), 32'd0);
        target = 5'd9; tick(); check_pc_lvl("call5", 5, 4);
        check("ovf_fault", 32'(fault), 32'd1);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_udf", 32'(underflow), 32'd0);
        call = 1'b0; jump = 1'b1; tick(); check_pc_lvl("fault_hold", 5, 4);
        check("fault_sticky", 32'(overflow), 32'd1);
        idle_strobes();

        // LIFO order of returns
        do_reset();
        tick();
        call = 1'b1; target = 5'd10; tick(); check_pc_lvl("lifo_c1", 10, 1);
        target = 5'd20; tick(); check_pc_lvl("lifo_c2", 20, 2);
        call = 1'b0; ret = 1'b1; tick(); check_pc_lvl("lifo_r1", 11, 1);
        tick(); check_pc_lvl("lifo_r2", 2, 0);
        ret = 1'b0;

        // Wrapping return address, then underflow
        jump = 1'b1; target = 5'd31; tick(); check_pc_lvl("jump31", 31, 0);
        jump = 1'b0; call = 1'b1; target = 5'd8; tick(); check_pc_lvl("wrap_call", 8, 1);
        call = 1'b0; ret = 1'b1; tick(); check_pc_lvl("wrap_ret", 0, 0);
        tick(); check_pc_lvl("udf", 0, 0);
        check("udf_fault", 32'(fault), 32'd1);
        check("udf_flag", 32'(underflow), 32'd1);
        check("udf_ovf", 32'(overflow), 32'd0);
        idle_strobes();

        // Halt / resume
        do_reset();
        jump = 1'b1; target = 5'd6; tick(); check_pc_lvl("pre_halt", 6, 0);
        jump = 1'b0; halt = 1'b1; tick();
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_pc", 32'(instruction_address), 32'd6);
        halt = 1'b0; target = 5'd15;
        for (int i = 0; i < 5; i++) begin
            jump = (i % 2 == 0);
            call = (i % 2 == 1);
            tick();
            check_pc_lvl("halt_hold", 6, 0);
            check("halt_still", 32'(halted), 32'd1);
        end
        jump = 1'b0; call = 1'b0; resume = 1'b1; tick();
        check("resume_pc", 32'(instruction_address), 32'd7);
        check("resume_halted", 32'(halted), 32'd0);
        resume = 1'b0;

        // Stall with a pending call, then call+ret collision
        jump = 1'b1; target = 5'd4; tick(); check_pc_lvl("pre_stall", 4, 0);
        jump = 1'b0; stall = 1'b1; call = 1'b1; target = 5'd12;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_pc_lvl("stall_hold", 4, 0);
        end
        stall = 1'b0; tick(); check_pc_lvl("stall_release", 12, 1);
        ret = 1'b1; tick(); check_pc_lvl("call_ret", 5, 0);
        check("call_ret_fault", 32'(fault), 32'd0);
        idle_strobes();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
Parametrised successor to the fixed 5-bit program counter in the accumulator CPU. It generates the instruction address each cycle and supports stall, unconditional jump, carry-conditional branch, call/return through a hardware return stack, and halt/resume. Fault detection on stack overflow or underflow is included. It sits between the instruction decoder, which drives the control strobes, and program memory, which consumes instruction_address.

Parameters:
ADDR_WIDTH, 5, width of instruction address; program space is 2^ADDR_WIDTH words
STACK_DEPTH, 4, number of return-stack entries (>=1)
RESET_ADDR, 0, address loaded on reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
stall  input  1  hold PC and stack this cycle
jump  input  1  load target unconditionally
branch  input  1  load target if cond=1
cond  input  1  branch condition (ALU carry flag)
call  input  1  push return address, load target
ret  input  1  pop return address into PC
halt  input  1  enter HALT, PC held
resume  input  1  leave HALT
target  input  ADDR_WIDTH  jump/branch/call destination
instruction_address  output  ADDR_WIDTH  current PC, registered
halted  output  1  state==HALT
fault  output  1  state==FAULT
overflow  output  1  sticky: call with stack full
underflow  output  1  sticky: ret with stack empty
stack_level  output  $clog2(STACK_DEPTH+1)  entries currently on stack

Behaviour:
- Reset (rst=0, asynchronous): instruction_address=RESET_ADDR, state RUN, stack_level=0, overflow=underflow=0, halted=fault=0. All stack entries are cleared to 0. Reset mid-call or mid-halt discards everything.
- All outputs are registered. The effect of strobes sampled at edge N is visible after edge N.
- States are RUN, HALT and FAULT.
- RUN with stall=1: PC, stack and state are held. All strobes are ignored.
- RUN with stall=0: the single highest-priority strobe acts, in this order: halt > ret > call > jump > (branch&cond) > increment.
  - halt: PC held, go to HALT.
  - ret with level>0: PC=top entry, level-1.
  - ret with level==0: PC held, underflow=1, go to FAULT.
  - call with level<STACK_DEPTH: push PC+1 (mod 2^ADDR_WIDTH), PC=target, level+1.
  - call with level==STACK_DEPTH: PC held, overflow=1, go to FAULT. The stack is unchanged.
  - jump: PC=target.
  - branch with cond=1: PC=target.
  - branch with cond=0: falls through to increment.
  - increment: PC=PC+1, wrapping from 2^ADDR_WIDTH-1 to 0.
- HALT: PC and stack are held. The stall and control strobes are ignored. resume=1 sets PC=PC+1 (wrapping) and returns to RUN; the halt at PC is not re-executed.
- FAULT: everything is held. Only reset exits FAULT. overflow/underflow stay set until reset.
- Pushing to the last slot (level becomes STACK_DEPTH) is legal. Only the next call faults.
- Simultaneous call+ret: ret wins; call is ignored that cycle.
- cond is only sampled when branch is the winning strobe.

Decomposition:
- Shared package cpu_pkg:
  - seq_state_t enum {SEQ_RUN, SEQ_HALT, SEQ_FAULT}
  - localparam default ADDR_WIDTH
- One sub-module, return_stack (LIFO):
  - Parameters WIDTH and DEPTH.
  - Ports: push, pop, push_data, top, level, full, empty.
  - Async active-low reset.
  - The parent guarantees push and pop are never both asserted, and never asserted into full or from empty respectively.

Test Plan:
- Reset then 33 plain cycles with ADDR_WIDTH=5 -> PC steps 0,1,…,31,0,1; wrap observed.
- PC=3, jump target=20 -> PC=20 next cycle. Then branch target=7 with cond=0 -> 21; with cond=1 -> 7.
- STACK_DEPTH=4; call targets 10,20,30,5 from PCs 1,10,20,30 -> level 4 with top=31 (30+1). A fifth call -> fault=1, overflow=1, PC held at 5, level 4. Then rst low -> PC=0, flags cleared.
- Nested call at PC=31 to 8 -> pushed return address 0 (wrap). ret -> PC=0, level 0. A further ret -> underflow=1, fault=1.
- halt at PC=6 -> halted=1, PC stays 6 for 5 cycles despite jump/call pulses. resume -> PC=7, halted=0.
- stall held 3 cycles with call asserted at PC=4 -> PC=4, level unchanged. Release stall with call still high -> PC=target, level+1. call+ret together at level 1 -> pop only.
